// File: rtl/pong_match_ctrl.sv
// Pong match sequencer, evaluated once per video frame.
// Decides when the ball is held at centre, when it moves and when it is
// frozen; detects goals from the ball position, keeps both scores, and
// runs the serve delay, the post-goal pause, player pause and game-over.
module pong_match_ctrl #(
  parameter int          WIN_SCORE    = 7,
  parameter int          SERVE_FRAMES = 60,
  parameter int          POINT_FRAMES = 30,
  parameter int          GOAL_L       = 34,
  parameter int          GOAL_R       = 595,
  parameter logic [7:0]  KEY_START    = 8'h2C,
  parameter logic [7:0]  KEY_PAUSE    = 8'h13
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallS,
  output logic       BallHold,
  output logic       BallEn,
  output logic       ServeDir,
  output logic [3:0] Score1,
  output logic [3:0] Score2,
  output logic       GameOver,
  output logic       Winner,
  output logic [2:0] GameState
);

  // Match phases; the code doubles as the GameState debug/HUD value.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [10:0] GOAL_L_X   = 11'(GOAL_L);
  localparam logic [10:0] GOAL_R_X   = 11'(GOAL_R);

  logic [2:0]  state, state_next;
  logic [7:0]  timer, timer_next;
  logic [7:0]  key_prev;
  logic [3:0]  score1_next, score2_next;
  logic [3:0]  score1_inc, score2_inc;
  logic        dir_next, winner_next;
  logic        start_press, pause_press;
  logic [10:0] ball_x, ball_s, left_edge, right_edge;
  logic        goal_l, goal_r;

  // A held key reports one press: only the frame where it first appears.
  assign start_press = (keycode == KEY_START) && (key_prev != KEY_START);
  assign pause_press = (keycode == KEY_PAUSE) && (key_prev != KEY_PAUSE);

  // Goal lines are checked on the ball's outer edges in 11 bits so the
  // right edge cannot overflow; a ball straddling x = 0 counts as a left goal.
  assign ball_x     = {1'b0, BallX};
  assign ball_s     = {1'b0, BallS};
  assign left_edge  = ball_x - ball_s;
  assign right_edge = ball_x + ball_s;
  assign goal_l     = (ball_x < ball_s) || (left_edge <= GOAL_L_X);
  assign goal_r     = (right_edge >= GOAL_R_X);

  assign score1_inc = Score1 + 4'd1;
  assign score2_inc = Score2 + 4'd1;

  // Next-state, timer, score and serve-direction decisions for this frame.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_next  = state;
    timer_next  = timer;
    score1_next = Score1;
    score2_next = Score2;
    dir_next    = ServeDir;
    winner_next = Winner;
    case (state)
      S_IDLE: begin
        if (start_press) begin
          state_next  = S_SERVE;
          timer_next  = '0;
          score1_next = '0;
          score2_next = '0;
        end
      end
      S_SERVE: begin
        if (timer == SERVE_LAST) begin
          state_next = S_PLAY;
          timer_next = '0;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      S_PLAY: begin
        // A goal outranks a pause request arriving in the same frame.
        if (goal_l) begin
          score2_next = score2_inc;
          dir_next    = 1'b0;
          if (score2_inc == WIN) begin
            state_next  = S_OVER;
            winner_next = 1'b1;
          end else begin
            state_next = S_POINT;
            timer_next = '0;
          end
        end else if (goal_r) begin
          score1_next = score1_inc;
          dir_next    = 1'b1;
          if (score1_inc == WIN) begin
            state_next  = S_OVER;
            winner_next = 1'b0;
          end else begin
            state_next = S_POINT;
            timer_next = '0;
          end
        end else if (pause_press) begin
          state_next = S_PAUSE;
        end
      end
      S_POINT: begin
        if (timer == POINT_LAST) begin
          state_next = S_SERVE;
          timer_next = '0;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      S_PAUSE: begin
        if (pause_press) state_next = S_PLAY;
      end
      S_OVER: begin
        if (start_press) state_next = S_IDLE;
      end
      default: begin
        // Unused codes recover to IDLE on the next frame.
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Frame-rate state, counters, scores and key history.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      key_prev <= '0;
      Score1   <= '0;
      Score2   <= '0;
      ServeDir <= 1'b1;
      Winner   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state    <= state_next;
      timer    <= timer_next;
      key_prev <= keycode;
      Score1   <= score1_next;
      Score2   <= score2_next;
      ServeDir <= dir_next;
      Winner   <= winner_next;
    end
  end

  // Ball control decoded from the registered state only (Moore outputs).
  always_comb begin
    BallHold = 1'b1;
    BallEn   = 1'b0;
    case (state)
      S_PLAY: begin
        BallHold = 1'b0;
        BallEn   = 1'b1;
      end
      S_PAUSE: begin
        BallHold = 1'b0;
        BallEn   = 1'b0;
      end
      default: begin
        BallHold = 1'b1;
        BallEn   = 1'b0;
      end
    endcase
  end

  assign GameOver  = (state == S_OVER);
  assign GameState = state;

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the Pong game. It runs once per video frame and decides when the ball datapath is held at centre, when it advances, and when it is frozen. It detects goals from ball position, keeps both players' scores, and handles serve delay, pause and game-over. It sits between the keyboard keycode path, the ball datapath (BallHold/BallEn/ServeDir) and the score/HUD display logic.

Parameters:
WIN_SCORE, 7, score that ends the match (1..15)
SERVE_FRAMES, 60, frames the ball is held at centre before each serve (1..255)
POINT_FRAMES, 30, frames of post-goal pause before the next serve (1..255)
GOAL_L, 34, left goal line, in pixels
GOAL_R, 595, right goal line, in pixels
KEY_START, 8'h2C, start/restart keycode (space)
KEY_PAUSE, 8'h13, pause toggle keycode (P)

Ports:
frame_clk  in  1  frame-rate clock (vsync); the only clock
Reset  in  1  asynchronous, active-high reset
keycode  in  8  current keyboard keycode; 0 when no key is pressed
BallX  in  10  ball centre X
BallS  in  10  ball half-size
BallHold  out  1  level; 1 forces the ball to centre with no motion
BallEn  out  1  level; 1 allows the ball position and motion to update this frame
ServeDir  out  1  serve X direction: 1 = rightward, 0 = leftward
Score1  out  4  left player's score
Score2  out  4  right player's score
GameOver  out  1  1 while in state OVER
Winner  out  1  0 = player1 won, 1 = player2 won; valid while GameOver = 1
GameState  out  3  state code for debug and HUD

Behaviour:
- All registers use posedge frame_clk, with asynchronous Reset.
- Reset values:
  - state IDLE
  - Score1 = Score2 = 0
  - timer = 0
  - ServeDir = 1
  - Winner = 0
  - key_prev = 0
- Key press detection:
  - a press is defined as keycode == K and key_prev != K.
  - key_prev <= keycode every frame.
  - Holding a key gives exactly one press.
- Goal detection, combinational, using 11-bit unsigned arithmetic:
  - goalL = (BallX < BallS) or (BallX - BallS <= GOAL_L).
  - goalR = (BallX + BallS >= GOAL_R).
  - Goals are evaluated only in PLAY.
  - If goalL and goalR are both true, goalL wins.
- Outputs by state (code: BallHold/BallEn):
  - IDLE = 0: 1/0
  - SERVE = 1: 1/0
  - PLAY = 2: 0/1
  - POINT = 3: 1/0
  - PAUSE = 4: 0/0
  - OVER = 5: 1/0
  - Codes 6 and 7 are illegal and return to IDLE on the next frame.
  - Outputs are Moore and registered through the state register, so they change on the frame after the triggering event.
- Transitions:
  - IDLE: start press -> SERVE, timer <= 0, scores cleared.
  - SERVE: timer++ each frame; when timer == SERVE_FRAMES-1 -> PLAY, timer <= 0. Keys are ignored.
  - PLAY, priority goal > pause:
    - goalL: Score2++ and ServeDir <= 0 (serve toward the conceding player1). If the new Score2 == WIN_SCORE -> OVER with Winner <= 1, else -> POINT with timer <= 0.
    - goalR: Score1++ and ServeDir <= 1. If the new Score1 == WIN_SCORE -> OVER with Winner <= 0, else -> POINT.
    - Pause press with no goal -> PAUSE.
  - POINT: timer++; when timer == POINT_FRAMES-1 -> SERVE, timer <= 0.
  - PAUSE: pause press -> PLAY. Start press is ignored. BallHold = 0, so the ball keeps its position.
  - OVER: GameOver = 1, scores are frozen; start press -> IDLE.
- Scores never exceed WIN_SCORE. They are cleared only on Reset and on the IDLE->SERVE transition.
- Timer is 8 bits and does not wrap within the legal parameter ranges.
- A Reset mid-match returns everything to reset values immediately, with BallHold = 1.

Test Plan:
- Reset, then keycode 2C for 1 frame -> frame+1 GameState=1, BallHold=1; after 60 frames GameState=2, BallEn=1, BallHold=0.
- Hold keycode 2C for 10 frames in IDLE -> exactly one transition to SERVE; a further hold in SERVE has no effect.
- In PLAY, drive BallX=36, BallS=4 -> next frame Score2=1, ServeDir=0, GameState=3; after 30 frames GameState=1.
- In PLAY, keycode 13 pulse -> GameState=4, BallEn=0, BallHold=0; second 13 pulse -> GameState=2. A 13 pulse in the same frame as BallX=600, BallS=4 -> Score1 increments, GameState=3 (goal wins).
- Score1=6 and a right goal -> GameOver=1, Winner=0, Score1=7, further goals ignored; keycode 2C -> IDLE, then 2C -> scores 0, GameState=1.
- Assert Reset during PAUSE with Score2=3 -> immediately Score2=0, GameState=0, BallHold=1, ServeDir=1.
